// File: rtl/avg_seq_ctrl.sv
// Averaging sequencer: accumulates NSAMP signed samples, then runs NSHIFT arithmetic shift passes.
// Define AVG_SAT_EN to saturate avg to the DW-bit signed range instead of wrapping.
//   state | meaning
//   IDLE  | waiting for start
//   ACCUM | accepting samples into the accumulator
//   SHIFT | NSHIFT passes of acc >>> sa
//   OUT   | avg held with out_valid until out_ready
module avg_seq_ctrl #(
  parameter int DW     = 16,
  parameter int NSAMP  = 8,
  parameter int NSHIFT = 3
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [7:0]           sa,
  input  logic signed [DW-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic signed [DW-1:0] avg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int CW = $clog2(NSAMP) + 1;
  localparam int PW = (NSHIFT > 1) ? $clog2(NSHIFT) : 1;
  localparam logic [CW-1:0] LAST_CNT  = CW'(NSAMP - 1);
  localparam logic [PW-1:0] LAST_PASS = PW'(NSHIFT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SHIFT, S_OUT} state_t;

  state_t                state_q, state_d;
  logic signed [31:0]    acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [7:0]            sa_q, sa_d;
  logic [PW-1:0]         pass_q, pass_d;
  logic signed [DW-1:0]  avg_q, avg_d;
  logic signed [31:0]    acc_shr;
  logic signed [DW-1:0]  avg_next;

  // Shifts of 32 or more collapse to pure sign bits.
  assign acc_shr = (sa_q >= 8'd32) ? {32{acc_q[31]}} : (acc_q >>> sa_q[4:0]);

`ifdef AVG_SAT_EN
  localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (DW - 1)) - 32'sd1;
  localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< (DW - 1));
  always_comb begin
    avg_next = DW'(acc_shr);
    if (acc_shr > SAT_MAX)      avg_next = DW'(SAT_MAX);
    else if (acc_shr < SAT_MIN) avg_next = DW'(SAT_MIN);
  end
`else
  assign avg_next = acc_shr[DW-1:0];
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    pass_d  = pass_q;
    avg_d   = avg_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          sa_d    = sa;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          acc_d = acc_q + 32'(in_data);
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = S_SHIFT;
            pass_d  = LAST_PASS;
          end
        end
      end
      S_SHIFT: begin
        acc_d  = acc_shr;
        pass_d = pass_q - PW'(1);
        if (pass_q == '0) begin
          state_d = S_OUT;
          avg_d   = avg_next;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sa_q    <= '0;
      pass_q  <= '0;
      avg_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      pass_q  <= pass_d;
      avg_q   <= avg_d;
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign avg       = avg_q;

endmodule
